// File: rtl/tx_rr_scheduler.sv
// Round-robin owner of the shared TX serializer. It latches the winning packet,
// pulses start, acks on tx_ready and aborts a hung frame via a watchdog.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; arbitrate among req starting at the rr pointer
// BUSY    | frame in flight; data/grant frozen, watchdog counting
// RELEASE | one dead cycle so the acked source can drop req
module tx_rr_scheduler #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 55,
   parameter int TIMEOUT = 80,
   parameter int TO_W    = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          i_req,
   input  logic [N_REQ*DATA_W-1:0]   i_pkt_data,
   output logic [N_REQ-1:0]          o_ack,
   output logic [N_REQ-1:0]          o_grant,
   output logic [DATA_W-1:0]         o_tx_data,
   output logic                      o_tx_start,
   input  logic                      i_tx_ready,
   output logic                      o_tx_abort,
   output logic                      o_busy,
   output logic [7:0]                o_err_cnt
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_ptr;
   logic [IDX_W-1:0]    r_owner;
   logic [TO_W-1:0]     r_wd;
   logic [N_REQ-1:0]    r_ack;
   logic [N_REQ-1:0]    r_grant;
   logic [DATA_W-1:0]   r_tx_data;
   logic                r_tx_start;
   logic                r_tx_abort;
   logic                r_busy;
   logic [7:0]          r_err_cnt;

   logic                w_found;
   logic [IDX_W-1:0]    w_sel;
   logic [IDX_W:0]      w_sum;
   logic [IDX_W-1:0]    w_idx;
   logic [N_REQ-1:0]    w_sel_oh;
   logic [DATA_W-1:0]   w_sel_data;
   logic [IDX_W-1:0]    w_ptr_nxt;
   logic                w_timeout;

   // First requester at or above the pointer, wrapping modulo N_REQ.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
         if (w_sum >= (IDX_W+1)'(N_REQ)) begin
            w_sum = w_sum - (IDX_W+1)'(N_REQ);
         end
         w_idx = w_sum[IDX_W-1:0];
         if (!w_found && i_req[w_idx]) begin
            w_found = 1'b1;
            w_sel   = w_idx;
         end
      end
   end

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_sel == IDX_W'(i)) begin
            w_sel_data = i_pkt_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_sel_oh  = N_REQ'(1) << w_sel;
   assign w_ptr_nxt = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
   assign w_timeout = (r_wd == WD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_found) w_state_nxt = S_BUSY;
         S_BUSY:    if (i_tx_ready || w_timeout) w_state_nxt = S_RELEASE;
         S_RELEASE: w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr      <= '0;
         r_owner    <= '0;
         r_wd       <= '0;
         r_ack      <= '0;
         r_grant    <= '0;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
         r_tx_abort <= 1'b0;
         r_busy     <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         r_tx_start <= 1'b0;
         r_tx_abort <= 1'b0;
         r_ack      <= '0;
         r_busy     <= (w_state_nxt != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_tx_data  <= w_sel_data;
                  r_grant    <= w_sel_oh;
                  r_owner    <= w_sel;
                  r_tx_start <= 1'b1;
                  r_wd       <= '0;
               end
            end
            S_BUSY: begin
               r_wd <= r_wd + 1'b1;
               // A late tx_ready coinciding with the timeout still counts as success.
               if (i_tx_ready) begin
                  r_ack   <= r_grant;
                  r_grant <= '0;
                  r_ptr   <= w_ptr_nxt;
               end else if (w_timeout) begin
                  r_tx_abort <= 1'b1;
                  r_grant    <= '0;
                  r_ptr      <= w_ptr_nxt;
                  if (r_err_cnt != 8'hFF) begin
                     r_err_cnt <= r_err_cnt + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ack      = r_ack;
   assign o_grant    = r_grant;
   assign o_tx_data  = r_tx_data;
   assign o_tx_start = r_tx_start;
   assign o_tx_abort = r_tx_abort;
   assign o_busy     = r_busy;
   assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_tx_rr_scheduler.sv
// Bench for tx_rr_scheduler: random packets/requests against a frame-level
// model tracking the rr pointer and timeout count.
module tb_tx_rr_scheduler;
   localparam int N  = 4;
   localparam int DW = 55;
   localparam int TO = 80;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      i_req = '0;
   logic [N*DW-1:0]   i_pkt_data = '0;
   logic              i_tx_ready = 1'b0;
   logic [N-1:0]      o_ack, o_grant;
   logic [DW-1:0]     o_tx_data;
   logic              o_tx_start, o_tx_abort, o_busy;
   logic [7:0]        o_err_cnt;

   int errors = 0;
   int checks = 0;
   int m_ptr  = 0;
   int m_err  = 0;

   tx_rr_scheduler #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO), .TO_W(7)) dut (
      .clk(clk), .rst(rst), .i_req(i_req), .i_pkt_data(i_pkt_data),
      .o_ack(o_ack), .o_grant(o_grant), .o_tx_data(o_tx_data),
      .o_tx_start(o_tx_start), .i_tx_ready(i_tx_ready), .o_tx_abort(o_tx_abort),
      .o_busy(o_busy), .o_err_cnt(o_err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [N*DW-1:0] rand_pkt();
      logic [223:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return t[N*DW-1:0];
   endfunction

   function automatic int pick(input logic [N-1:0] r, input int ptr);
      for (int i = 0; i < N; i++) begin
         if (r[(ptr + i) % N]) return (ptr + i) % N;
      end
      return 0;
   endfunction

   // One full frame starting from an IDLE negedge; ready_at=0 means the
   // transmitter never answers. Returns the model's winner in w.
   task automatic do_frame(input logic [N-1:0] req, input int ready_at,
                           input int drop_at, output int w);
      logic [N-1:0]  oh, x_grant, x_ack;
      logic [DW-1:0] x_data;
      logic          x_start, x_abort, x_busy;
      bit            rdy;
      int            e;
      i_req  = req;
      w      = pick(req, m_ptr);
      oh     = N'(1) << w;
      x_data = i_pkt_data[w*DW +: DW];
      rdy    = (ready_at > 0) && (ready_at <= TO - 1);
      e      = rdy ? ready_at : TO - 1;
      @(negedge clk);
      for (int k = 0; k <= e + 2; k++) begin
         if (k > 0) @(negedge clk);
         if (k == e + 1 && !rdy && m_err < 255) m_err++;
         x_start = (k == 0);
         x_grant = (k <= e) ? oh : '0;
         x_ack   = (k == e + 1 && rdy) ? oh : '0;
         x_abort = (k == e + 1 && !rdy);
         x_busy  = (k <= e + 1);
         checks++; if (o_tx_start !== x_start) begin errors++; $display("FAIL tx_start k=%0d got=%b exp=%b", k, o_tx_start, x_start); end
         checks++; if (o_grant !== x_grant) begin errors++; $display("FAIL grant k=%0d got=%b exp=%b", k, o_grant, x_grant); end
         checks++; if (o_ack !== x_ack) begin errors++; $display("FAIL ack k=%0d got=%b exp=%b", k, o_ack, x_ack); end
         checks++; if (o_tx_abort !== x_abort) begin errors++; $display("FAIL tx_abort k=%0d got=%b exp=%b", k, o_tx_abort, x_abort); end
         checks++; if (o_busy !== x_busy) begin errors++; $display("FAIL busy k=%0d got=%b exp=%b", k, o_busy, x_busy); end
         checks++; if (o_tx_data !== x_data) begin errors++; $display("FAIL tx_data k=%0d got=%h exp=%h", k, o_tx_data, x_data); end
         checks++; if (o_err_cnt !== 8'(m_err)) begin errors++; $display("FAIL err_cnt k=%0d got=%0d exp=%0d", k, o_err_cnt, m_err); end
         if (k <= e) begin
            i_req      = (N'($urandom) & ~oh) | ((drop_at > 0 && k >= drop_at) ? '0 : oh);
            i_tx_ready = rdy && (k == e);
         end else if (k == e + 1) begin
            i_req      = N'($urandom);
            i_tx_ready = 1'($urandom);
         end else begin
            i_req      = '0;
            i_tx_ready = 1'($urandom);
         end
         i_pkt_data = rand_pkt();
      end
      m_ptr = (w + 1) % N;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; i_req = '0; i_tx_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_ptr = 0; m_err = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (o_ack !== '0) begin errors++; $display("FAIL reset_ack got=%b exp=0", o_ack); end
      checks++; if (o_grant !== '0) begin errors++; $display("FAIL reset_grant got=%b exp=0", o_grant); end
      checks++; if (o_tx_data !== '0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0", o_tx_data); end
      checks++; if (o_tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", o_tx_start); end
      checks++; if (o_tx_abort !== 1'b0) begin errors++; $display("FAIL reset_tx_abort got=%b exp=0", o_tx_abort); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
      checks++; if (o_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", o_err_cnt); end
   endtask

   task automatic test_single();
      int w;
      i_pkt_data = rand_pkt();
      i_pkt_data[2*DW +: DW] = 55'h12_3456_789A_BCDE;
      do_frame(4'b0100, 63, 0, w);
      checks++; if (w !== 2) begin errors++; $display("FAIL single_winner got=%0d exp=2", w); end
   endtask

   task automatic test_round_robin();
      int w;
      apply_reset();
      for (int j = 0; j < 5; j++) begin
         i_pkt_data = rand_pkt();
         do_frame(4'b1111, $urandom_range(1, 70), 0, w);
         checks++; if (w !== j % 4) begin errors++; $display("FAIL rr_order j=%0d got=%0d exp=%0d", j, w, j % 4); end
      end
   endtask

   task automatic test_wrap();
      int w;
      i_pkt_data = rand_pkt();
      do_frame(4'b1000, $urandom_range(1, 40), 0, w);
      checks++; if (w !== 3) begin errors++; $display("FAIL wrap_first got=%0d exp=3", w); end
      i_pkt_data = rand_pkt();
      do_frame(4'b1001, $urandom_range(1, 40), 0, w);
      checks++; if (w !== 0) begin errors++; $display("FAIL wrap_next got=%0d exp=0", w); end
   endtask

   task automatic test_timeout();
      int w;
      apply_reset();
      i_pkt_data = rand_pkt();
      do_frame(4'b0010, 0, 0, w);
      checks++; if (w !== 1) begin errors++; $display("FAIL to_first got=%0d exp=1", w); end
      checks++; if (o_err_cnt !== 8'd1) begin errors++; $display("FAIL to_err_cnt got=%0d exp=1", o_err_cnt); end
      do_frame(4'b0010, 20, 0, w);
      checks++; if (w !== 1) begin errors++; $display("FAIL to_same_src got=%0d exp=1", w); end
      do_frame(4'b1010, 0, 0, w);
      checks++; if (w !== 3) begin errors++; $display("FAIL to_third got=%0d exp=3", w); end
      do_frame(4'b1010, 15, 0, w);
      checks++; if (w !== 1) begin errors++; $display("FAIL to_other_src got=%0d exp=1", w); end
      checks++; if (o_err_cnt !== 8'd2) begin errors++; $display("FAIL to_err_total got=%0d exp=2", o_err_cnt); end
   endtask

   task automatic test_collision();
      int w;
      do_frame(4'b0100, 79, 0, w);
      checks++; if (o_err_cnt !== 8'd2) begin errors++; $display("FAIL coll_err_cnt got=%0d exp=2", o_err_cnt); end
   endtask

   task automatic test_drop_and_random();
      int w;
      do_frame(4'b0001, 40, 10, w);
      for (int j = 0; j < 8; j++) begin
         logic [N-1:0] r;
         r = N'($urandom_range(1, 15));
         do_frame(r, (j % 3 == 0) ? 0 : $urandom_range(1, 79), $urandom_range(0, 30), w);
      end
   endtask

   task automatic test_idle_ready();
      for (int j = 0; j < 4; j++) begin
         i_req = '0; i_tx_ready = 1'b1;
         @(negedge clk);
         checks++; if (o_busy !== 1'b0 || o_ack !== '0) begin errors++; $display("FAIL idle_ready busy=%b ack=%b exp busy=0 ack=0", o_busy, o_ack); end
         checks++; if (o_err_cnt !== 8'(m_err)) begin errors++; $display("FAIL idle_ready_err got=%0d exp=%0d", o_err_cnt, m_err); end
      end
      i_tx_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int w;
      i_req = 4'b0100; i_pkt_data = rand_pkt();
      repeat (21) @(negedge clk);
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got=%b exp=1", o_busy); end
      #1 rst = 1'b1;
      #1;
      checks++; if (o_grant !== '0) begin errors++; $display("FAIL mid_grant got=%b exp=0", o_grant); end
      checks++; if (o_tx_data !== '0) begin errors++; $display("FAIL mid_tx_data got=%h exp=0", o_tx_data); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", o_busy); end
      @(negedge clk);
      rst = 1'b0; m_ptr = 0; m_err = 0;
      i_pkt_data = rand_pkt();
      do_frame(4'b0110, 30, 0, w);
      checks++; if (w !== 1) begin errors++; $display("FAIL mid_first_grant got=%0d exp=1", w); end
   endtask

   task automatic test_saturate();
      int w;
      while (m_err < 255) do_frame(N'($urandom_range(1, 15)), 0, 0, w);
      do_frame(4'b0010, 0, 0, w);
      checks++; if (o_err_cnt !== 8'd255) begin errors++; $display("FAIL sat_err_cnt got=%0d exp=255", o_err_cnt); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_timeout();
      test_collision();
      test_drop_and_random();
      test_idle_ready();
      test_reset_mid();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tx_rr_scheduler.md
Name: tx_rr_scheduler

Overview:
- Round-robin scheduler that shares one serial frame transmitter among N_REQ packet sources in the router TX path.
- Each source raises a request with a 55-bit packet. The scheduler picks a winner, latches its packet, pulses the transmitter start and holds the data stable for the whole frame.
- It acknowledges the source when the transmitter reports ready.
- A watchdog aborts the transmitter if ready never arrives; this is the recovery path for a hung serializer.

Parameters:
- N_REQ, 4, number of requesting sources (2..8)
- DATA_W, 55, packet width; must match the transmitter data width
- TIMEOUT, 80, cycles in BUSY without tx_ready before abort; a nominal frame is 63 cycles
- TO_W, 7, watchdog counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
- clk, input, 1, clock, rising edge
- rst, input, 1, asynchronous, active-high reset
- req, input, N_REQ, per-source request; level, held until ack
- pkt_data, input, N_REQ*DATA_W, source i packet on bits [i*DATA_W +: DATA_W]
- ack, output, N_REQ, one-cycle pulse to the source whose frame completed
- grant, output, N_REQ, one-hot owner of the transmitter; 0 when idle
- tx_data, output, DATA_W, latched packet driven to the transmitter
- tx_start, output, 1, one-cycle start pulse to the transmitter
- tx_ready, input, 1, one-cycle frame-done pulse from the transmitter
- tx_abort, output, 1, one-cycle pulse, ORed into the transmitter reset
- busy, output, 1, high while state is BUSY or RELEASE
- err_cnt, output, 8, saturating count of timeouts

Behaviour:
- Reset (asynchronous, rst=1):
  - state IDLE, rr pointer 0, watchdog 0.
  - ack, grant, tx_data, tx_start, tx_abort, busy and err_cnt all 0.
- All outputs are registered.
- State IDLE:
  - Sample req. If any bit is set, select the first set bit searching upward from the pointer, wrapping modulo N_REQ; call it w.
  - At the next edge: tx_data <= slice w of pkt_data, grant <= onehot(w), tx_start <= 1, watchdog <= 0, state -> BUSY.
  - Latency from req sampled in IDLE to tx_start high is 1 cycle.
  - If no req is set, remain in IDLE.
- State BUSY:
  - tx_start returns to 0 after exactly one cycle.
  - The watchdog increments every cycle.
  - tx_data and grant are held constant; changes on pkt_data or req have no effect.
  - On tx_ready=1: ack[w] <= 1 for one cycle, grant <= 0, pointer <= (w+1) mod N_REQ, state -> RELEASE.
  - Else if watchdog == TIMEOUT-1:
    - tx_abort <= 1 for one cycle; err_cnt increments, saturating at 255.
    - No ack is issued. grant <= 0, pointer <= (w+1) mod N_REQ, state -> RELEASE.
    - The aborted source keeps req high and re-competes.
  - tx_ready and timeout in the same cycle: tx_ready wins (ack, no abort, no err_cnt increment).
- State RELEASE:
  - Lasts one cycle; req is ignored.
  - This gives a source with registered logic time to drop req after seeing ack.
  - Next edge -> IDLE.
- tx_ready while in IDLE or RELEASE is ignored and does not count as an error.
- A source that drops req during BUSY still has its frame completed and still receives its ack.
- Minimum spacing between consecutive tx_start pulses is frame time + 2 cycles. This guarantees the transmitter is back in WAIT and sees a fresh single-cycle start.
- Fairness: after any grant to w, completed or aborted, w has the lowest priority. With all sources requesting, the grant order is strictly rotating.
- rst asserted mid-frame returns to IDLE immediately with all outputs 0. Pending reqs are re-arbitrated from source 0.

Test Plan:
- Single request: after reset, req=4'b0100, pkt_data[2] = 55'h12_3456_789A_BCDE.
  - tx_start pulses 1 cycle after req, with grant=4'b0100 and tx_data equal to that value.
  - With the real transmitter attached, tx_ready arrives 63 cycles after tx_start, ack[2] pulses on the next cycle, and busy drops 2 cycles after tx_ready.
- Round-robin rotation: req=4'b1111 held high, each source re-presenting after ack.
  - Grant order is 0,1,2,3,0.
  - Every tx_start is exactly one cycle wide, and tx_data matches the granted slice on every frame.
- Pointer wrap: first grant to source 3, then req=4'b1001.
  - The next grant goes to source 0, not source 3.
- Timeout: tie tx_ready=0, req=4'b0010.
  - tx_abort pulses exactly 80 cycles after tx_start; err_cnt goes 0->1; no ack.
  - The next grant goes to the other requester if one is present, else back to source 1.
- Collision: tx_ready asserted on the same cycle the watchdog hits 79.
  - ack pulses, no tx_abort, err_cnt unchanged.
- Reset and stale inputs:
  - Assert rst 20 cycles into BUSY: grant, tx_data and busy go to 0 asynchronously. After release with req=4'b0110, the first grant is source 1.
  - Separately, change pkt_data[w] mid-frame: tx_data does not change.
